// File: rtl/gb_mapper_multimode.sv
// Multi-mode Game Boy cartridge mapper (DETECT / MBC1 / MBC5).
// Synchronises the cartridge bus strobes to the CPLD clock, commits register
// writes on the synchronised /WR rising edge, and drives the banked high
// address lines for ROM and RAM plus the FRAM chip enable.
module gb_mapper_multimode #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4,
    parameter int FORCE_MODE    = 0
) (
    input  logic                                          reset,
    input  logic                                          clock,
    input  logic [3:0]                                    inputAddress,
    input  logic [7:0]                                    inputData,
    input  logic                                          inputCE,
    input  logic                                          inputRD,
    input  logic                                          inputWR,
    output logic [ROM_BANK_BITS-1:0]                      romHighAddress,
    output logic [((RAM_BANK_BITS > 0) ? RAM_BANK_BITS : 1)-1:0] ramHighAddress,
    output logic                                          ramCE,
    output logic [1:0]                                    mapperMode
);

    // A zero-width RAM bank still needs one physical bit; it is held at 0.
    localparam int RAM_W = (RAM_BANK_BITS > 0) ? RAM_BANK_BITS : 1;

    typedef enum logic [1:0] {
        DETECT = 2'd0,
        MBC1   = 2'd1,
        MBC5   = 2'd2
    } mode_t;

    localparam mode_t INIT_MODE = (FORCE_MODE == 1) ? MBC1 :
                                  (FORCE_MODE == 5) ? MBC5 : DETECT;

    // Bit-field masks on the ROM bank register, truncated to its real width.
    localparam logic [ROM_BANK_BITS-1:0] ROM_ONE  = ROM_BANK_BITS'(9'h001);
    localparam logic [ROM_BANK_BITS-1:0] MASK_LO8 = ROM_BANK_BITS'(9'h0FF);
    localparam logic [ROM_BANK_BITS-1:0] MASK_LO5 = ROM_BANK_BITS'(9'h01F);
    localparam logic [ROM_BANK_BITS-1:0] MASK_B65 = ROM_BANK_BITS'(9'h060);

    // Synchroniser chains; bit 1 is the synchronised value.
    logic [1:0] rdSync;
    logic [1:0] wrSync;
    logic [1:0] ceSync;
    logic       wrPrev;

    // Write capture.
    logic [3:0] addrCap;
    logic [7:0] dataCap;

    // Mapper state.
    mode_t                     state;
    logic [ROM_BANK_BITS-1:0]  romBank;
    logic [RAM_W-1:0]          ramBank;
    logic                      ramEnabled;
    logic                      mbc1Mode;
    logic                      zeroSeen;
    logic                      modeSeen;

    // Decode results.
    logic rdSynced;
    logic wrSynced;
    logic ceSynced;
    logic wrRise;
    logic regWrite;
    logic ramEnNext;
    logic ramSelect;
    logic detectZero;
    logic detectMode;
    logic detectLock;
    logic [4:0] mbc1Low5;

    assign rdSynced   = rdSync[1];
    assign wrSynced   = wrSync[1];
    assign ceSynced   = ceSync[1];
    assign mapperMode = state;

    // Two-flop synchronisers for the bus strobes, idle high out of reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            rdSync <= 2'b11;
            wrSync <= 2'b11;
            ceSync <= 2'b11;
            wrPrev <= 1'b1;
        end else begin
            rdSync <= {rdSync[0], inputRD};
            wrSync <= {wrSync[0], inputWR};
            ceSync <= {ceSync[0], inputCE};
            wrPrev <= wrSynced;
        end
    end

    // Track address and data while the synchronised /WR is low; the values
    // held at the rising edge are the ones committed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addrCap <= 4'h0;
            dataCap <= 8'h00;
        end else if (!wrSynced) begin
            addrCap <= inputAddress;
            dataCap <= inputData;
        end
    end

    // Write decode and the look-ahead RAM enable used by both the register
    // file and the chip-enable path, so a disabling write wins immediately.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no
        // latch can be inferred.
        wrRise     = !wrPrev && wrSynced;
        regWrite   = wrRise && !addrCap[3];
        ramEnNext  = ramEnabled;
        if (regWrite && (addrCap[2:1] == 2'b00)) begin
            ramEnNext = (dataCap[3:0] == 4'hA);
        end
        ramSelect  = (inputAddress[3:1] == 3'b101) && !ceSynced;
        detectZero = (addrCap[2:1] == 2'b01) && (dataCap == 8'h00);
        detectMode = (addrCap[2:1] == 2'b11);
        detectLock = ((addrCap[2:0] == 3'h2) && (dataCap >= 8'd32)) ||
                     ((addrCap[2:0] == 3'h3) && dataCap[0]);
        mbc1Low5   = (dataCap[4:0] == 5'd0) ? 5'd1 : dataCap[4:0];
    end

    // Mode state machine and bank registers, updated on each committed write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INIT_MODE;
            romBank    <= ROM_ONE;
            ramBank    <= '0;
            ramEnabled <= 1'b0;
            mbc1Mode   <= 1'b0;
            zeroSeen   <= 1'b0;
            modeSeen   <= 1'b0;
        end else begin
            ramEnabled <= ramEnNext;
            if (regWrite) begin
                case (state)
                    MBC1: begin
                        case (addrCap[2:1])
                            2'b01: romBank <= (romBank & ~MASK_LO5) |
                                              ROM_BANK_BITS'(mbc1Low5);
                            2'b10: begin
                                if (mbc1Mode) begin
                                    ramBank <= RAM_W'(dataCap[1:0]);
                                end else begin
                                    romBank <= (romBank & ~MASK_B65) |
                                               ROM_BANK_BITS'({dataCap[1:0], 5'b00000});
                                end
                            end
                            2'b11: mbc1Mode <= dataCap[0];
                            default: ;
                        endcase
                    end
                    default: begin
                        // DETECT behaves as MBC5 except that bank 0 maps to 1.
                        case (addrCap[2:0])
                            3'h2: romBank <= (romBank & ~MASK_LO8) |
                                             ROM_BANK_BITS'(((state == DETECT) && (dataCap == 8'h00))
                                                            ? 8'h01 : dataCap);
                            3'h3: begin
                                if (ROM_BANK_BITS >= 9) begin
                                    romBank <= (romBank & MASK_LO8) |
                                               ROM_BANK_BITS'({dataCap[0], 8'h00});
                                end
                            end
                            3'h4, 3'h5: ramBank <= RAM_W'(dataCap);
                            default: ;
                        endcase
                        if (state == DETECT) begin
                            zeroSeen <= zeroSeen || detectZero;
                            modeSeen <= modeSeen || detectMode;
                            if (detectLock) begin
                                state <= MBC5;
                            end else if ((zeroSeen || detectZero) && (modeSeen || detectMode)) begin
                                state <= MBC1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Registered bus outputs: banked high address lines and FRAM /CE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            romHighAddress <= '0;
            ramHighAddress <= '0;
            ramCE          <= 1'b1;
        end else begin
            case (inputAddress[3:2])
                2'b00:   romHighAddress <= '0;
                2'b01:   romHighAddress <= romBank;
                default: ;
            endcase
            if ((RAM_BANK_BITS == 0) || ((state == MBC1) && !mbc1Mode)) begin
                ramHighAddress <= '0;
            end else begin
                ramHighAddress <= ramBank;
            end
            ramCE <= !(ramSelect && ramEnNext && (!rdSynced || !wrSynced));
        end
    end

endmodule

// File: tb/tb_gb_mapper_multimode.sv
// Self-checking bench for gb_mapper_multimode: a default auto-detect instance
// and a fixed-MBC5 instance with a 2-bit RAM bank share one cartridge bus.
module tb_gb_mapper_multimode;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] inputAddress = 4'hF;
    logic [7:0] inputData    = 8'hFF;
    logic       inputCE      = 1'b1;
    logic       inputRD      = 1'b1;
    logic       inputWR      = 1'b1;

    logic [8:0] romHighAddress;
    logic [3:0] ramHighAddress;
    logic       ramCE;
    logic [1:0] mapperMode;

    logic [8:0] romHigh5;
    logic [1:0] ramHigh5;
    logic       ramCE5;
    logic [1:0] mode5;

    always #5 clock = ~clock;

    gb_mapper_multimode dut (
        .reset          (reset),
        .clock          (clock),
        .inputAddress   (inputAddress),
        .inputData      (inputData),
        .inputCE        (inputCE),
        .inputRD        (inputRD),
        .inputWR        (inputWR),
        .romHighAddress (romHighAddress),
        .ramHighAddress (ramHighAddress),
        .ramCE          (ramCE),
        .mapperMode     (mapperMode)
    );

    gb_mapper_multimode #(
        .ROM_BANK_BITS (9),
        .RAM_BANK_BITS (2),
        .FORCE_MODE    (5)
    ) dut5 (
        .reset          (reset),
        .clock          (clock),
        .inputAddress   (inputAddress),
        .inputData      (inputData),
        .inputCE        (inputCE),
        .inputRD        (inputRD),
        .inputWR        (inputWR),
        .romHighAddress (romHigh5),
        .ramHighAddress (ramHigh5),
        .ramCE          (ramCE5),
        .mapperMode     (mode5)
    );

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        string      tag;
        bit         chkRom;
        logic [8:0] rom;
        logic [3:0] ram;
        logic       ce;
        logic [1:0] mode;
        bit         chk5;
        logic [8:0] rom5;
        logic [1:0] ram5;
        logic [1:0] mode5;
    } exp_t;

    exp_t scoreboard[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input string tag, input bit chkRom, input logic [8:0] rom,
                                   input logic [3:0] ram, input logic ce, input logic [1:0] mode);
        exp_t e;
        e.tag    = tag;
        e.chkRom = chkRom;
        e.rom    = rom;
        e.ram    = ram;
        e.ce     = ce;
        e.mode   = mode;
        e.chk5   = 1'b0;
        e.rom5   = 9'h000;
        e.ram5   = 2'b00;
        e.mode5  = 2'b00;
        return e;
    endfunction

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic compareNext();
        exp_t e;
        check("scoreboardDepth", 32'(scoreboard.size()), 32'd1);
        if (scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        if (e.chkRom) check({e.tag, ".rom"}, 32'(romHighAddress), 32'(e.rom));
        check({e.tag, ".ram"},  32'(ramHighAddress), 32'(e.ram));
        check({e.tag, ".ce"},   32'(ramCE),          32'(e.ce));
        check({e.tag, ".mode"}, 32'(mapperMode),     32'(e.mode));
        if (e.chk5) begin
            check({e.tag, ".rom5"},  32'(romHigh5), 32'(e.rom5));
            check({e.tag, ".ram5"},  32'(ramHigh5), 32'(e.ram5));
            check({e.tag, ".mode5"}, 32'(mode5),    32'(e.mode5));
        end
    endtask

    // Full bus write: /WR low for 4 clocks, address held well past the rise.
    task automatic busWrite(input logic [3:0] addr, input logic [7:0] data);
        inputAddress = addr;
        inputData    = data;
        inputCE      = (addr < 4'h8);
        @(negedge clock);
        inputWR = 1'b0;
        repeat (4) @(negedge clock);
        inputWR = 1'b1;
        repeat (4) @(negedge clock);
        inputCE      = 1'b1;
        inputAddress = 4'hF;
        inputData    = 8'hFF;
        repeat (2) @(negedge clock);
    endtask

    // Bus read: expectation queued at drive time, compared 4 clocks after
    // /RD falls; /CE must be released within 4 clocks of /RD returning high.
    task automatic busRead(input logic [3:0] addr, input exp_t e);
        scoreboard.push_back(e);
        inputAddress = addr;
        inputCE      = (addr < 4'h8);
        @(negedge clock);
        inputRD = 1'b0;
        repeat (4) @(negedge clock);
        compareNext();
        inputRD = 1'b1;
        repeat (4) @(negedge clock);
        check({e.tag, ".ceRelease"}, 32'(ramCE), 32'd1);
        inputCE      = 1'b1;
        inputAddress = 4'hF;
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".rom"},   32'(romHighAddress), 32'h0);
        check({tag, ".ram"},   32'(ramHighAddress), 32'h0);
        check({tag, ".ce"},    32'(ramCE),          32'h1);
        check({tag, ".mode"},  32'(mapperMode),     32'h0);
        check({tag, ".rom5"},  32'(romHigh5),       32'h0);
        check({tag, ".ram5"},  32'(ramHigh5),       32'h0);
        check({tag, ".ce5"},   32'(ramCE5),         32'h1);
        check({tag, ".mode5"}, 32'(mode5),          32'h2);
    endtask

    task automatic doReset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues(tag);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        // Power-up reset and default bank.
        doReset("rst0");
        busRead(4'h4, mkExp("bootRom", 1'b1, 9'h001, 4'h0, 1'b1, 2'd0));

        // RAM enable decode and the RAM address window boundaries.
        busWrite(4'h0, 8'h0A);
        busRead(4'hA, mkExp("ramOnA", 1'b0, 9'h000, 4'h0, 1'b0, 2'd0));
        busRead(4'hB, mkExp("ramOnB", 1'b0, 9'h000, 4'h0, 1'b0, 2'd0));
        busRead(4'hC, mkExp("ramAddrC", 1'b0, 9'h000, 4'h0, 1'b1, 2'd0));
        busRead(4'h9, mkExp("ramAddr9", 1'b0, 9'h000, 4'h0, 1'b1, 2'd0));
        busWrite(4'h0, 8'h00);
        busRead(4'hA, mkExp("ramOff", 1'b0, 9'h000, 4'h0, 1'b1, 2'd0));
        busWrite(4'h1, 8'h1A);
        busRead(4'hA, mkExp("ramOnNibble", 1'b0, 9'h000, 4'h0, 1'b0, 2'd0));
        busWrite(4'h0, 8'h0B);
        busRead(4'hA, mkExp("ramOffB", 1'b0, 9'h000, 4'h0, 1'b1, 2'd0));

        // Auto-detect into MBC1 and MBC1 banking.
        busWrite(4'h2, 8'h00);
        busRead(4'h4, mkExp("detectZero", 1'b1, 9'h001, 4'h0, 1'b1, 2'd0));
        busWrite(4'h6, 8'h01);
        busRead(4'h4, mkExp("toMbc1", 1'b1, 9'h001, 4'h0, 1'b1, 2'd1));
        busWrite(4'h4, 8'h02);
        busWrite(4'h2, 8'h03);
        busRead(4'h4, mkExp("mbc1Upper", 1'b1, 9'h043, 4'h0, 1'b1, 2'd1));
        busWrite(4'h2, 8'h00);
        busRead(4'h4, mkExp("mbc1Zero", 1'b1, 9'h041, 4'h0, 1'b1, 2'd1));
        busWrite(4'h2, 8'h40);
        busRead(4'h4, mkExp("mbc1Terminal", 1'b1, 9'h041, 4'h0, 1'b1, 2'd1));
        busWrite(4'h6, 8'h01);
        busWrite(4'h4, 8'h03);
        busRead(4'h4, mkExp("mbc1RamBank", 1'b1, 9'h041, 4'h3, 1'b1, 2'd1));
        busRead(4'h0, mkExp("bank0Area", 1'b1, 9'h000, 4'h3, 1'b1, 2'd1));

        // Auto-detect into MBC5 and MBC5 banking.
        doReset("rst1");
        busWrite(4'h2, 8'h40);
        busRead(4'h4, mkExp("toMbc5", 1'b1, 9'h040, 4'h0, 1'b1, 2'd2));
        busWrite(4'h3, 8'h01);
        busRead(4'h4, mkExp("mbc5Bit8", 1'b1, 9'h140, 4'h0, 1'b1, 2'd2));
        busWrite(4'h2, 8'h00);
        busRead(4'h4, mkExp("mbc5Zero", 1'b1, 9'h100, 4'h0, 1'b1, 2'd2));
        busWrite(4'h4, 8'h05);
        busRead(4'h4, mkExp("mbc5Ram", 1'b1, 9'h100, 4'h5, 1'b1, 2'd2));

        // Lock threshold: 31 stays in DETECT, 32 locks MBC5.
        doReset("rst2");
        busWrite(4'h2, 8'h1F);
        busRead(4'h4, mkExp("detect31", 1'b1, 9'h01F, 4'h0, 1'b1, 2'd0));
        busWrite(4'h2, 8'h20);
        busRead(4'h4, mkExp("lock32", 1'b1, 9'h020, 4'h0, 1'b1, 2'd2));

        // Lock via bit 0 of a 0x3xxx write.
        doReset("rst3");
        busWrite(4'h3, 8'h01);
        busRead(4'h4, mkExp("lockHigh", 1'b1, 9'h101, 4'h0, 1'b1, 2'd2));

        // Reset asserted in the middle of a /WR pulse aborts the write.
        inputAddress = 4'h2;
        inputData    = 8'h05;
        @(negedge clock);
        inputWR = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        inputWR = 1'b1;
        repeat (2) @(negedge clock);
        checkResetValues("resetAbort");
        inputAddress = 4'hF;
        inputData    = 8'hFF;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        busRead(4'h4, mkExp("afterAbort", 1'b1, 9'h001, 4'h0, 1'b1, 2'd0));

        // RAM bank truncation on the fixed-MBC5, 2-bit RAM instance.
        busWrite(4'h4, 8'h0F);
        e = mkExp("ramTrunc", 1'b1, 9'h001, 4'hF, 1'b1, 2'd0);
        e.chk5  = 1'b1;
        e.rom5  = 9'h001;
        e.ram5  = 2'b11;
        e.mode5 = 2'd2;
        busRead(4'h4, e);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/gb_mapper_multimode.md
Name: gb_mapper_multimode

Overview:
- Parametrised successor to the 2MB MBC5 hybrid CPLD mapper.
- Sits between the Game Boy cartridge bus and the flash ROM/FRAM.
- Synchronises bus strobes to a free-running CPLD clock and decodes register writes on the WR rising edge.
- Runs a DETECT → MBC1/MBC5 mode state machine and drives the banked high address lines for ROM and RAM, plus the RAM chip enable.

Parameters:
- ROM_BANK_BITS, 9: width of the ROM bank register, driving A14 upward. 9 gives 8MB; legal range 7–9.
- RAM_BANK_BITS, 4: width of the RAM bank register, driving RAM A13 upward. 4 gives 128KB; legal range 0–4.
- FORCE_MODE, 0: 0 = auto-detect, 1 = fixed MBC1, 5 = fixed MBC5.

Ports:
- reset  in  1  async active-low reset
- clock  in  1  free-running CPLD oscillator, ≥8 MHz
- inputAddress  in  4  cart A15–A12
- inputData  in  8  cart D7–D0
- inputCE  in  1  cart /CS, active-low
- inputRD  in  1  cart /RD, active-low
- inputWR  in  1  cart /WR, active-low
- romHighAddress  out  ROM_BANK_BITS  ROM A14 upward
- ramHighAddress  out  RAM_BANK_BITS  RAM A13 upward
- ramCE  out  1  FRAM /CE, active-low
- mapperMode  out  2  0 = DETECT, 1 = MBC1, 2 = MBC5 (debug)

Behaviour:
- **Reset (async, active-low):**
  - romBank=1, ramBank=0, ramEnabled=0, mbc1Mode=0.
  - romHighAddress=0, ramHighAddress=0, ramCE=1.
  - State = DETECT, or MBC1/MBC5 per FORCE_MODE.
  - Sync flops are cleared to the idle value 1.
  - Reset mid-write aborts that write; no register changes.
- **Synchronisers:** inputRD, inputWR and inputCE each pass through 2 flops.
- **Write commit:**
  - A write is a synced WR rising edge, i.e. previous 0 and current 1.
  - Address and data are captured on the sync cycle where WR is low.
  - The register updates 1 clock after the edge is detected, 3–4 clocks after the pin edge.
  - At most one write is processed per WR pulse.
  - A WR pulse shorter than 2 clocks may be missed; this is acceptable.
- **Decode for RAM accesses:** addresses 0xA–0xB with inputCE low.
- **Decode for register writes:** addresses 0x0–0x7, which are ROM-space writes.
- **Register writes, common to all modes:**
  - 0x0–0x1: ramEnabled = (data[3:0]==0xA).
- **MBC5 and DETECT modes:**
  - 0x2: romBank[7:0] = data.
  - 0x3: romBank[8] = data[0]. Ignored when ROM_BANK_BITS<9.
  - 0x4–0x5: ramBank = data[RAM_BANK_BITS-1:0].
  - In MBC5, bank 0 is legal at 0x4000.
  - In DETECT, a write of 0 to 0x2 stores 1.
- **MBC1 mode:**
  - 0x2–0x3: romBank[4:0] = data[4:0]. A value of 0 becomes 1.
  - 0x4–0x5, mbc1Mode=0: data[1:0] → romBank[6:5].
  - 0x4–0x5, mbc1Mode=1: data[1:0] → ramBank.
  - 0x6–0x7: mbc1Mode = data[0].
- **Mode FSM, auto mode only:**
  - DETECT tracks two flags: zeroSeen (0 written to 0x2xxx or 0x3xxx) and modeSeen (any write to 0x6–0x7).
  - DETECT → MBC1 when zeroSeen && modeSeen and not locked.
  - DETECT → MBC5 (locked) when either:
    - a value ≥32 is written to 0x2, or
    - any write to 0x3 has data[0]=1.
  - If both conditions occur on the same write, MBC5 wins.
  - MBC1 and MBC5 are terminal until reset.
  - Register values carry over on the transition.
- **Address outputs (registered; update the cycle after any register change or after a synced RD/WR falling edge):**
  - A15–A14 = 00: romHighAddress = 0.
  - A15–A14 = 01: romHighAddress = romBank, truncated to ROM_BANK_BITS.
  - ramHighAddress = ramBank in MBC5/DETECT.
  - In MBC1 with mbc1Mode=0, ramHighAddress = 0.
- **ramCE:**
  - Asserted low when all of these hold: RAM decode, ramEnabled=1, synced RD=0 or WR=0.
  - Deasserts within 1 clock of the synced RD and WR both returning high, of CE going high, or of ramEnabled clearing.
  - Never asserted for addresses 0x0–0x9 or 0xC–0xF.
- **Simultaneous events:**
  - A ramEnabled clear and a RAM access in the same cycle: the clear wins, ramCE=1.

Test Plan:
- Reset, then read 0x4000 → romHighAddress=1, ramCE=1, mapperMode=0.
- Write 0x0A to 0x0000, then read 0xA000 → ramCE goes 0 within 4 clocks. Write 0x00 → ramCE stays 1 on the next access.
- Auto mode: write 0x00 to 0x2000, then 0x01 to 0x6000 → mapperMode=1. Then write 0x02 to 0x4000 and 0x03 to 0x2000 → romHighAddress=0x43 at 0x4000, ramHighAddress=0.
- Auto mode: write 0x40 to 0x2000 → mapperMode=2. Then write 0x01 to 0x3000 → romHighAddress=0x140. Then write 0x00 to 0x2000 → romHighAddress=0x100.
- MBC5 mode: write 0x0F to 0x4000 with RAM_BANK_BITS=2 → ramHighAddress=3.
- Assert reset mid-WR-pulse during a write of 0x05 to 0x2000 → after reset romBank=1 and all outputs are at their reset values.
